// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the UART-to-ALU command bridge.
// Frame sizing helpers let the bridge derive byte counts from its data width.
package alu_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_A,
        S_RX_B,
        S_EXEC,
        S_TX_STAT,
        S_TX_RES,
        S_TX_ERR
    } state_e;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_OP  = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT = 8'hE2;

    function automatic int nbytes_of(input int nb_data);
        return nb_data / 8;
    endfunction

    function automatic int bidx_width_of(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

    localparam int NBYTES  = nbytes_of(16);
    localparam int NB_BIDX = bidx_width_of(NBYTES);

endpackage

// File: rtl/alu_uart_bridge_frame_timer.sv
// Inter-byte timeout counter: runs while a frame is being received, clears on each
// popped byte, saturates instead of wrapping, and flags expiry on the cycle it would reach the limit.
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int NB_TIMEOUT     = 17
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [NB_TIMEOUT-1:0] LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMEOUT-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i || !run_i) begin
            count_q <= '0;
        end else if (count_q != LIMIT) begin
            count_q <= count_q + 1'b1;
        end
    end

    // A pop on the expiry cycle wins, so clear_i masks the flag.
    assign expired_o = (TIMEOUT_CYCLES != 0) && run_i && !clear_i && (count_q == LIMIT);

endmodule

// File: rtl/alu_uart_bridge.sv
// Framed command bridge: pops [opcode][A][B] from the RX FIFO, drives the ALU,
// and pushes [status][result] (or a lone error status) to the TX FIFO.
module alu_uart_bridge
    import alu_uart_pkg::*;
#(
    parameter int NB_DATA        = 16,
    parameter int NB_OPCODE      = 6,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int NB_TIMEOUT     = 17
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_data_to_read,
    input  logic                 i_fifo_rx_empty,
    input  logic                 i_fifo_tx_full,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic                 o_fifo_rx_read,
    output logic                 o_fifo_tx_write,
    output logic [7:0]           o_data_to_write,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    output logic [NB_DATA-1:0]   o_alu_op_A,
    output logic [NB_DATA-1:0]   o_alu_op_B,
    output logic                 o_is_valid,
    output logic                 o_error
);

    localparam int NBYTES_P  = nbytes_of(NB_DATA);
    localparam int NB_BIDX_P = bidx_width_of(NBYTES_P);
    localparam logic [NB_BIDX_P-1:0] LAST_IDX = NB_BIDX_P'(NBYTES_P - 1);

    state_e                 state_q;
    logic [NB_BIDX_P-1:0]   idx_q;
    logic [NB_OPCODE-1:0]   opcode_q;
    logic [NB_DATA-1:0]     op_a_q;
    logic [NB_DATA-1:0]     op_b_q;
    logic [NB_DATA-1:0]     res_q;
    logic [7:0]             err_code_q;

    logic in_rx, in_tx, in_frame, rx_pop, tx_push, timer_expired;
    logic [7:0] opcode_upper;

    assign in_rx    = state_q inside {S_IDLE, S_RX_A, S_RX_B};
    assign in_tx    = state_q inside {S_TX_STAT, S_TX_RES, S_TX_ERR};
    assign in_frame = state_q inside {S_RX_A, S_RX_B};

    // Pop strobe is gated by reset so every output reads 0 while reset is held.
    assign rx_pop  = in_rx && !i_fifo_rx_empty && !i_reset;
    assign tx_push = in_tx && !i_fifo_tx_full;

    assign opcode_upper = i_data_to_read >> NB_OPCODE;

    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NB_TIMEOUT     (NB_TIMEOUT)
    ) u_frame_timer (
        .clk_i     (i_clk),
        .rst_i     (i_reset),
        .clear_i   (rx_pop),
        .run_i     (in_frame),
        .expired_o (timer_expired)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            opcode_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_q      <= '0;
            err_code_q <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_pop) begin
                        idx_q <= '0;
                        if (opcode_upper != 8'h00) begin
                            err_code_q <= ST_BAD_OP;
                            state_q    <= S_TX_ERR;
                        end else begin
                            opcode_q <= i_data_to_read[NB_OPCODE-1:0];
                            state_q  <= S_RX_A;
                        end
                    end
                end
                S_RX_A: begin
                    if (rx_pop) begin
                        op_a_q[{idx_q, 3'b000} +: 8] <= i_data_to_read;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= S_RX_B;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (timer_expired) begin
                        err_code_q <= ST_TIMEOUT;
                        state_q    <= S_TX_ERR;
                    end
                end
                S_RX_B: begin
                    if (rx_pop) begin
                        op_b_q[{idx_q, 3'b000} +: 8] <= i_data_to_read;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= S_EXEC;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (timer_expired) begin
                        err_code_q <= ST_TIMEOUT;
                        state_q    <= S_TX_ERR;
                    end
                end
                S_EXEC: begin
                    res_q   <= i_alu_result;
                    state_q <= S_TX_STAT;
                end
                S_TX_STAT: begin
                    if (tx_push) begin
                        idx_q   <= '0;
                        state_q <= S_TX_RES;
                    end
                end
                S_TX_RES: begin
                    if (tx_push) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_TX_ERR: begin
                    if (tx_push) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Byte source follows state/index, so it holds steady while the TX FIFO is full.
    always_comb begin
        o_data_to_write = 8'h00;
        case (state_q)
            S_TX_STAT: o_data_to_write = ST_OK;
            S_TX_RES:  o_data_to_write = res_q[{idx_q, 3'b000} +: 8];
            S_TX_ERR:  o_data_to_write = err_code_q;
            default:   o_data_to_write = 8'h00;
        endcase
    end

    assign o_fifo_rx_read  = rx_pop;
    assign o_fifo_tx_write = tx_push;
    assign o_alu_opcode    = opcode_q;
    assign o_alu_op_A      = op_a_q;
    assign o_alu_op_B      = op_b_q;
    assign o_is_valid      = (state_q == S_EXEC);
    assign o_error         = tx_push && (state_q == S_TX_ERR);

endmodule

// File: tb/tb_alu_uart_bridge.sv
// Directed bench for alu_uart_bridge: models both FIFOs and the ALU, and scores every
// TX byte against a queue of responses predicted when each command is queued.
module tb_alu_uart_bridge;

    localparam int NB_DATA   = 16;
    localparam int NB_OPCODE = 6;
    localparam int TIMEOUT   = 50;

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic [7:0]           i_data_to_read;
    logic                 i_fifo_rx_empty;
    logic                 i_fifo_tx_full;
    logic [NB_DATA-1:0]   i_alu_result;
    logic                 o_fifo_rx_read;
    logic                 o_fifo_tx_write;
    logic [7:0]           o_data_to_write;
    logic [NB_OPCODE-1:0] o_alu_opcode;
    logic [NB_DATA-1:0]   o_alu_op_A;
    logic [NB_DATA-1:0]   o_alu_op_B;
    logic                 o_is_valid;
    logic                 o_error;

    alu_uart_bridge #(
        .NB_DATA        (NB_DATA),
        .NB_OPCODE      (NB_OPCODE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .NB_TIMEOUT     (17)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_data_to_read  (i_data_to_read),
        .i_fifo_rx_empty (i_fifo_rx_empty),
        .i_fifo_tx_full  (i_fifo_tx_full),
        .i_alu_result    (i_alu_result),
        .o_fifo_rx_read  (o_fifo_rx_read),
        .o_fifo_tx_write (o_fifo_tx_write),
        .o_data_to_write (o_data_to_write),
        .o_alu_opcode    (o_alu_opcode),
        .o_alu_op_A      (o_alu_op_A),
        .o_alu_op_B      (o_alu_op_B),
        .o_is_valid      (o_is_valid),
        .o_error         (o_error)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    int         wr_edges[$];
    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int last_pop_edge = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    function automatic logic [NB_DATA-1:0] alu_model(input logic [NB_OPCODE-1:0] op,
                                                     input logic [NB_DATA-1:0] a,
                                                     input logic [NB_DATA-1:0] b);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        i_fifo_rx_empty = (rx_q.size() == 0);
        i_data_to_read  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
        i_alu_result    = alu_model(o_alu_opcode, o_alu_op_A, o_alu_op_B);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_q.push_back(b);
        refresh();
    endtask

    task automatic push_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = alu_model(op[NB_OPCODE-1:0], a, b);
        push_rx(op); push_rx(a[7:0]); push_rx(a[15:8]); push_rx(b[7:0]); push_rx(b[15:8]);
        exp_tx.push_back(8'h00); exp_tx.push_back(r[7:0]); exp_tx.push_back(r[15:8]);
        $display("queued frame op=%02h A=%04h B=%04h expect R=%04h", op, a, b, r);
    endtask

    // One clock: sample outputs on the falling edge, apply FIFO effects just after the rising edge.
    task automatic tick();
        logic rd, wr;
        logic [7:0] wd, e;
        @(negedge i_clk);
        rd = o_fifo_rx_read;
        wr = o_fifo_tx_write;
        wd = o_data_to_write;
        if (o_is_valid) valid_cnt++;
        if (o_error) err_cnt++;
        if (wr) wr_edges.push_back(edge_no + 1);
        @(posedge i_clk);
        edge_no++;
        #1;
        if (rd) begin
            last_pop_edge = edge_no;
            void'(rx_q.pop_front());
        end
        if (wr) begin
            chk("tx_expected_pending", (exp_tx.size() != 0), 1);
            if (exp_tx.size() != 0) begin
                e = exp_tx.pop_front();
                chk("tx_byte", wd, e);
                $display("edge %0d: TX byte %02h (expected %02h)", edge_no, wd, e);
            end
        end
        refresh();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_tx.size() != 0 || rx_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, exp_tx.size(), 0);
        tick(); tick();
    endtask

    task automatic wait_rx_empty(input string tag);
        int n = 0;
        while (rx_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_rx_consumed"}, rx_q.size(), 0);
    endtask

    initial begin
        int p, q, v0, n;
        i_reset        = 1'b1;
        i_fifo_tx_full = 1'b0;
        refresh();
        tick(); tick();
        chk("reset_outputs", {o_fifo_rx_read, o_fifo_tx_write, o_data_to_write, o_alu_opcode,
                              o_alu_op_A, o_alu_op_B, o_is_valid, o_error}, 64'd0);
        i_reset = 1'b0;
        tick();

        // Basic ADD with 2-clock pop-to-status latency
        wr_edges.delete();
        push_frame(8'h20, 16'h1234, 16'h0001);
        drain("add", 40);
        chk("add_valid_pulses", valid_cnt, 1);
        chk("add_opcode", o_alu_opcode, 6'h20);
        chk("add_op_a", o_alu_op_A, 16'h1234);
        chk("add_op_b", o_alu_op_B, 16'h0001);
        chk("add_no_error", err_cnt, 0);
        chk("add_write_count", wr_edges.size(), 3);
        if (wr_edges.size() == 3) begin
            chk("add_latency", wr_edges[0] - last_pop_edge, 2);
            chk("add_consecutive", wr_edges[2] - wr_edges[0], 2);
        end

        // Bad opcode, then a clean frame straight after
        push_rx(8'hC0);
        exp_tx.push_back(8'hE1);
        drain("badop", 20);
        chk("badop_error_pulse", err_cnt, 1);
        chk("badop_opcode_held", o_alu_opcode, 6'h20);
        push_frame(8'h22, 16'h0100, 16'h0001);
        drain("sub", 40);
        chk("sub_opcode", o_alu_opcode, 6'h22);
        chk("sub_valid_pulses", valid_cnt, 2);

        // Timeout after two bytes of silence-terminated frame
        wr_edges.delete();
        push_rx(8'h20); push_rx(8'h34);
        exp_tx.push_back(8'hE2);
        drain("timeout", 120);
        chk("timeout_error_pulse", err_cnt, 2);
        chk("timeout_write_count", wr_edges.size(), 1);
        // Strobe rises 50 clocks after the pop; the byte is taken on the following edge.
        if (wr_edges.size() == 1) chk("timeout_delay", wr_edges[0] - last_pop_edge, TIMEOUT + 1);

        // Late bytes at 49 clocks and exactly on the expiry edge are still accepted
        exp_tx.push_back(8'h00); exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0F);
        push_rx(8'h24); push_rx(8'hF0);
        wait_rx_empty("late1");
        p = last_pop_edge;
        for (int i = 0; i < TIMEOUT - 2; i++) tick();
        push_rx(8'h0F);
        tick();
        chk("late_pop_49", last_pop_edge - p, TIMEOUT - 1);
        q = last_pop_edge;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        push_rx(8'hFF);
        tick();
        chk("late_pop_expiry_edge", last_pop_edge - q, TIMEOUT);
        push_rx(8'hFF);
        drain("late", 40);
        chk("late_no_error", err_cnt, 2);

        // TX backpressure for 40 cycles after EXEC
        i_fifo_tx_full = 1'b1;
        wr_edges.delete();
        v0 = valid_cnt;
        push_frame(8'h20, 16'h00FF, 16'h0001);
        n = 0;
        while (valid_cnt == v0 && n < 20) begin
            tick();
            n++;
        end
        chk("full_valid_seen", valid_cnt, v0 + 1);
        for (int i = 0; i < 40; i++) tick();
        chk("full_no_writes", wr_edges.size(), 0);
        i_fifo_tx_full = 1'b0;
        drain("full_release", 20);
        chk("full_write_count", wr_edges.size(), 3);
        if (wr_edges.size() == 3) begin
            chk("full_consec_1", wr_edges[1] - wr_edges[0], 1);
            chk("full_consec_2", wr_edges[2] - wr_edges[1], 1);
        end

        // Reset after three frame bytes
        push_rx(8'h20); push_rx(8'h34); push_rx(8'h12);
        wait_rx_empty("midreset");
        i_reset = 1'b1;
        #1;
        chk("midreset_outputs", {o_fifo_rx_read, o_fifo_tx_write, o_data_to_write, o_alu_opcode,
                                 o_alu_op_A, o_alu_op_B, o_is_valid, o_error}, 64'd0);
        tick();
        i_reset = 1'b0;
        refresh();
        push_frame(8'h20, 16'h0005, 16'h0007);
        drain("after_reset", 40);
        chk("after_reset_op_a", o_alu_op_A, 16'h0005);

        // Two frames back-to-back in the RX FIFO
        v0 = valid_cnt;
        push_frame(8'h22, 16'h0010, 16'h0020);
        push_frame(8'h20, 16'hFFFF, 16'h0002);
        drain("b2b", 100);
        chk("b2b_valid_pulses", valid_cnt, v0 + 2);
        chk("b2b_op_b", o_alu_op_B, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
